// File: rtl/operand_sequencer.sv
// operand_sequencer
// Collects two operands in sequence from a shared operand bus (valid/ready),
// holds them as a stable pair on op_a/op_b and presents them to the ALU units
// with a valid/ack handshake. Counts completed pairs and supports a
// synchronous flush.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high reset
//   bus_data   : operand word offered by the upstream bus
//   bus_valid  : bus_data valid this cycle
//   bus_ready  : sequencer accepts bus_data this cycle
//   seq_flush  : synchronous abort of a partial or presented pair
//   op_a       : first operand (registered)
//   op_b       : second operand (registered)
//   op_valid   : op_a/op_b form a complete pair (registered)
//   op_ack     : downstream consumes the pair this cycle
//   op_count   : completed pair count, wrap-around (registered)
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | awaiting operand A
// WAIT_B  | A captured, awaiting operand B
// PRESENT | pair valid on op_a/op_b, waiting for op_ack

module operand_sequencer #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     bus_data,
  input  logic                 bus_valid,
  output logic                 bus_ready,
  input  logic                 seq_flush,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic                 op_valid,
  input  logic                 op_ack,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     op_a_nxt, op_b_nxt;
  logic [CNT_WIDTH-1:0] op_count_nxt;
  logic                 accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      op_count <= '0;
    end else begin
      state    <= state_nxt;
      op_a     <= op_a_nxt;
      op_b     <= op_b_nxt;
      op_count <= op_count_nxt;
    end
  end

  // op_valid is a pure decode of the state register, so it is registered.
  assign op_valid = (state == PRESENT);

  always_comb begin
    state_nxt    = state;
    op_a_nxt     = op_a;
    op_b_nxt     = op_b;
    op_count_nxt = op_count;

    // In PRESENT the bus is only opened when the pair is being consumed, which
    // lets A of the next pair be taken in the ack cycle (one pair / 2 cycles).
    if (reset || seq_flush)
      bus_ready = 1'b0;
    else if (state == PRESENT)
      bus_ready = op_ack;
    else
      bus_ready = 1'b1;

    accept = bus_valid && bus_ready;

    if (seq_flush) begin
      // Drop any partial or presented pair; operands and count are kept.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a_nxt  = bus_data;
            state_nxt = WAIT_B;
          end
        end
        WAIT_B: begin
          if (accept) begin
            op_b_nxt  = bus_data;
            state_nxt = PRESENT;
          end
        end
        PRESENT: begin
          if (op_ack) begin
            op_count_nxt = op_count + 1'b1;
            if (accept) begin
              op_a_nxt  = bus_data;
              state_nxt = WAIT_B;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Upstream feeder for the 8-bit ALU logic units (OR, AND, ADD) of the Tiny-CPU datapath. It collects two operands in sequence from a shared 8-bit operand bus using a valid/ready handshake, holds them stable as a pair on `op_a`/`op_b`, and presents them to the ALU units with a valid/ack handshake. It counts completed operand pairs for debug visibility and supports a synchronous flush.

## Interface
- `WIDTH`, default 8: operand width; drives `bus_data`, `op_a` and `op_b`.
- `CNT_WIDTH`, default 8: width of the `op_count` completion counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `bus_data` in WIDTH: operand word offered by the upstream bus.
- `bus_valid` in 1: `bus_data` is valid this cycle.
- `bus_ready` out 1: sequencer accepts `bus_data` this cycle.
- `seq_flush` in 1: synchronous abort of a partially collected or presented pair.
- `op_a` out WIDTH: first operand, registered.
- `op_b` out WIDTH: second operand, registered.
- `op_valid` out 1: `op_a`/`op_b` form a complete pair.
- `op_ack` in 1: downstream ALU stage consumes the pair this cycle.
- `op_count` out CNT_WIDTH: number of completed pairs, wrap-around.

## Operation
- **States.** IDLE (awaiting A), WAIT_B (awaiting B), PRESENT (pair valid).
- **Accept.** A bus word is accepted when `bus_valid && bus_ready` is true at a clock edge.
- **IDLE.** `bus_ready`=1. On accept: `op_a`<=`bus_data`, go to WAIT_B.
- **WAIT_B.** `bus_ready`=1. On accept: `op_b`<=`bus_data`, go to PRESENT.
- **PRESENT.** `op_valid`=1 and `bus_ready`=`op_ack` (combinational pass-through).
  - If `op_ack` and no accept: `op_count`+=1, go to IDLE.
  - If `op_ack` and accept (back-to-back): `op_count`+=1, `op_a`<=`bus_data`, go to WAIT_B.
  - If no `op_ack`: hold state. `op_a`/`op_b` stay stable and `bus_data` is ignored.
- **Output ownership.** `op_valid` = (state==PRESENT). `op_a`/`op_b` change only on the accepts listed above.
- **`op_ack` outside PRESENT** is ignored and has no effect.
- **`op_count`.** Modulo 2^CNT_WIDTH: 255 -> 0 at CNT_WIDTH=8. No saturation.
- **Priority.** `reset` > `seq_flush` > normal operation.
- **`seq_flush`.**
  - State goes to IDLE in every state.
  - `op_a`/`op_b`/`op_count` are unchanged.
  - No bus word is accepted that cycle: `bus_ready` is forced to 0.
  - A pair in PRESENT is dropped and not counted, even if `op_ack` is high that cycle.
- **Reset.**
  - State goes to IDLE; `op_a`=0, `op_b`=0, `op_valid`=0, `op_count`=0.
  - `bus_ready`=0 while `reset` is high. It is 1 in the first cycle after release.
  - Reset mid-operation discards any partial or presented pair.

## Timing
- **Latency.** From A accept to `op_valid` high is 2 cycles at minimum (A accepted at edge N, B at edge N+1, `op_valid` high after edge N+1).
- **Throughput.** Sustained rate is one pair per 2 cycles when `bus_valid` and `op_ack` are held high.
- **Combinational paths.** `bus_ready` depends combinationally on `op_ack`, `seq_flush` and `reset`. There is no other input-to-output combinational path.
- **Registered outputs.** `op_a`, `op_b`, `op_valid` and `op_count` are all registered.

## Test plan
- **Reset values.** Assert `reset` for 2 cycles with `bus_valid`=1 and `bus_data`=8'hFF.
  - Required: `bus_ready`=0 during reset, all outputs 0, no capture.
  - First cycle after release: `bus_ready`=1.
- **Basic pair.** Drive `bus_data` 8'h0F, then 8'hA0 with `bus_valid`=1, and hold `op_ack`=0.
  - Required: `op_valid`=1, `op_a`=8'h0F, `op_b`=8'hA0, `bus_ready`=0, all stable for 5 cycles.
  - Then pulse `op_ack`: `op_count`=1 and return to IDLE.
- **Back-to-back.** Stream 8'h01, 8'h02, 8'h03, 8'h04 with `op_ack` held at 1.
  - Required: pair (01,02) is presented and acked in the same cycle that 03 is accepted; then pair (03,04).
  - Required: `op_count`=2 after the second ack.
- **Flush.**
  - Assert `seq_flush` in WAIT_B after A=8'h55. Required: return to IDLE, `op_a` still 8'h55, `op_valid` never asserted.
  - Assert `seq_flush` together with `op_ack` in PRESENT. Required: `op_count` unchanged, `bus_ready`=0 that cycle.
- **Counter wrap.** Complete 256 pairs. Required: `op_count` reads 8'hFF after 255 pairs and 8'h00 after 256.
- **Handshake stall.** Toggle `bus_valid` randomly in IDLE and WAIT_B.
  - Required: capture only on `bus_valid` && `bus_ready` edges.
  - Required: `op_ack` pulses in IDLE and WAIT_B have no effect on `op_count`.
